// File: rtl/seq_step_ctrl.sv
// rtl/seq_step_ctrl.sv - debounced step/clear controller for the 3-bit mod-8 state counter
//
// Purpose:
//   Conditions the raw S1 step button and the clear button (2-FF synchronizer
//   plus debouncer each), turns a press/release of S1 into one single-cycle
//   step strobe, and keeps the mod-8 counter state, its carry and a carry
//   count as registered outputs for the LED bus.
//
// Optional feature (macro STEP_AUTO_EN):
//   When defined, a synchronized sw_auto=1 runs a prescaler that issues a
//   step every AUTO_DIV clocks and holds the manual path idle. When not
//   defined, sw_auto is accepted but unused.
//
// Ports:
//   sys_clk_in  in   1  system clock
//   sys_rst_n   in   1  asynchronous active-low reset
//   btn_step    in   1  raw step button, active-high, asynchronous
//   btn_clr     in   1  raw clear button, active-high, asynchronous
//   sw_auto     in   1  raw auto-run switch, active-high
//   step_o      out  1  one-cycle step strobe
//   state_o     out  3  counter state {y3,y2,y1}
//   carry_o     out  1  carry (z) of the most recent step
//   carry_cnt   out  8  carries since reset/clear, mod 256

module seq_step_ctrl #(
   parameter int DB_CYCLES = 2000000,
   parameter int AUTO_DIV  = 50000000
) (
   input  logic       sys_clk_in,
   input  logic       sys_rst_n,
   input  logic       btn_step,
   input  logic       btn_clr,
   input  logic       sw_auto,
   output logic       step_o,
   output logic [2:0] state_o,
   output logic       carry_o,
   output logic [7:0] carry_cnt
);

   localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [DB_W-1:0] DB_MAX = DB_W'(DB_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_PRESSED = 2'd1,
      S_STEP    = 2'd2
   } fsm_t;

   // ---------------------------------------------------------------
   // Synchronizers
   // ---------------------------------------------------------------
   logic [1:0] step_sync_q;
   logic [1:0] clr_sync_q;

   // ---------------------------------------------------------------
   // Debouncers
   // ---------------------------------------------------------------
   logic            step_stable_q, step_stable_d;
   logic [DB_W-1:0] step_cnt_q, step_cnt_d;
   logic            clr_stable_q, clr_stable_d;
   logic [DB_W-1:0] clr_cnt_q, clr_cnt_d;
   logic            clr_prev_q;
   logic            clr_pulse;

   // ---------------------------------------------------------------
   // Step FSM and counter state
   // ---------------------------------------------------------------
   fsm_t       fsm_q, fsm_d;
   logic       step_q, step_d;
   logic [2:0] ctr_q, ctr_d;
   logic       carry_q, carry_d;
   logic [7:0] ccnt_q, ccnt_d;

`ifdef STEP_AUTO_EN
   localparam int AUTO_W = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;
   localparam logic [AUTO_W-1:0] AUTO_MAX = AUTO_W'(AUTO_DIV - 1);

   logic [1:0]        auto_sync_q;
   logic              auto_act;
   logic [AUTO_W-1:0] presc_q, presc_d;

   assign auto_act = auto_sync_q[1];
`else
   // sw_auto is kept on the port list so the top level is the same in both builds.
   logic unused_sw_auto;
   assign unused_sw_auto = sw_auto;
`endif

   // A stable value only moves after the synced input has disagreed with it
   // for DB_CYCLES consecutive clocks; any agreement restarts the count.
   always_comb begin
      step_stable_d = step_stable_q;
      step_cnt_d    = '0;
      if (step_sync_q[1] != step_stable_q) begin
         if (step_cnt_q == DB_MAX) begin
            step_stable_d = step_sync_q[1];
         end else begin
            step_cnt_d = step_cnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      clr_stable_d = clr_stable_q;
      clr_cnt_d    = '0;
      if (clr_sync_q[1] != clr_stable_q) begin
         if (clr_cnt_q == DB_MAX) begin
            clr_stable_d = clr_sync_q[1];
         end else begin
            clr_cnt_d = clr_cnt_q + 1'b1;
         end
      end
   end

   // One-cycle clear on the rising edge of the debounced clear button.
   assign clr_pulse = clr_stable_q & ~clr_prev_q;

   // Step FSM: a step is issued on release, not on press, so a held button
   // produces nothing until it is let go.
   always_comb begin
      fsm_d  = fsm_q;
      step_d = 1'b0;
      if (clr_pulse) begin
         fsm_d = S_IDLE;
`ifdef STEP_AUTO_EN
      end else if (auto_act) begin
         fsm_d  = S_IDLE;
         step_d = (presc_q == AUTO_MAX);
`endif
      end else begin
         case (fsm_q)
            S_IDLE: begin
               if (step_stable_q) begin
                  fsm_d = S_PRESSED;
               end
            end
            S_PRESSED: begin
               if (!step_stable_q) begin
                  fsm_d = S_STEP;
               end
            end
            S_STEP: begin
               fsm_d  = S_IDLE;
               step_d = 1'b1;
            end
            default: begin
               fsm_d = S_IDLE;
            end
         endcase
      end
   end

`ifdef STEP_AUTO_EN
   always_comb begin
      presc_d = '0;
      if (!clr_pulse && auto_act && (presc_q != AUTO_MAX)) begin
         presc_d = presc_q + 1'b1;
      end
   end
`endif

   // A clear landing on the same cycle as a registered step masks the strobe
   // so the outside world never sees a step that did not take effect.
   assign step_o = step_q & ~clr_pulse;

   always_comb begin
      ctr_d   = ctr_q;
      carry_d = carry_q;
      ccnt_d  = ccnt_q;
      if (clr_pulse) begin
         ctr_d   = 3'd0;
         carry_d = 1'b0;
         ccnt_d  = 8'd0;
      end else if (step_o) begin
         ctr_d   = ctr_q + 3'd1;
         carry_d = (ctr_q == 3'd7);
         if (ctr_q == 3'd7) begin
            ccnt_d = ccnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge sys_clk_in or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         step_sync_q   <= 2'b00;
         clr_sync_q    <= 2'b00;
         step_stable_q <= 1'b0;
         step_cnt_q    <= '0;
         clr_stable_q  <= 1'b0;
         clr_cnt_q     <= '0;
         clr_prev_q    <= 1'b0;
         fsm_q         <= S_IDLE;
         step_q        <= 1'b0;
         ctr_q         <= 3'd0;
         carry_q       <= 1'b0;
         ccnt_q        <= 8'd0;
`ifdef STEP_AUTO_EN
         auto_sync_q   <= 2'b00;
         presc_q       <= '0;
`endif
      end else begin
         step_sync_q   <= {step_sync_q[0], btn_step};
         clr_sync_q    <= {clr_sync_q[0], btn_clr};
         step_stable_q <= step_stable_d;
         step_cnt_q    <= step_cnt_d;
         clr_stable_q  <= clr_stable_d;
         clr_cnt_q     <= clr_cnt_d;
         clr_prev_q    <= clr_stable_q;
         fsm_q         <= fsm_d;
         step_q        <= step_d;
         ctr_q         <= ctr_d;
         carry_q       <= carry_d;
         ccnt_q        <= ccnt_d;
`ifdef STEP_AUTO_EN
         auto_sync_q   <= {auto_sync_q[0], sw_auto};
         presc_q       <= presc_d;
`endif
      end
   end

   assign state_o   = ctr_q;
   assign carry_o   = carry_q;
   assign carry_cnt = ccnt_q;

endmodule

// File: tb/tb_seq_step_ctrl.sv
// tb/tb_seq_step_ctrl.sv - self-checking bench for seq_step_ctrl

module tb_seq_step_ctrl;

   localparam int DB  = 4;
   localparam int DIV = 8;
   localparam int HN  = DB + 2;

   logic       clk;
   logic       rst_n;
   logic       btn_step;
   logic       btn_clr;
   logic       sw_auto;
   logic       step_o;
   logic [2:0] state_o;
   logic       carry_o;
   logic [7:0] carry_cnt;

   seq_step_ctrl #(.DB_CYCLES(DB), .AUTO_DIV(DIV)) dut (
      .sys_clk_in (clk),
      .sys_rst_n  (rst_n),
      .btn_step   (btn_step),
      .btn_clr    (btn_clr),
      .sw_auto    (sw_auto),
      .step_o     (step_o),
      .state_o    (state_o),
      .carry_o    (carry_o),
      .carry_cnt  (carry_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int printed  = 0;
   int pulses   = 0;
   bit cmp_en   = 1'b1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         if (printed < 40) begin
            printed++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
         end
      end
   endtask

   // Behavioural model: raw samples per clock edge, a button counts as
   // settled once the synced value (raw two edges back) has disagreed with
   // the settled value for DB consecutive edges. A settled release schedules
   // a step two cycles later unless a clear lands in the window around it.
   int m_hs [HN];
   int m_hc [HN];
   int m_st_step, m_st_clr;
   int m_cyc, m_last_fall, m_last_clr;
   int m_clr, m_step;
   int m_state, m_carry, m_cnt;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < HN; i++) begin
            m_hs[i] = 0;
            m_hc[i] = 0;
         end
         m_st_step = 0; m_st_clr = 0;
         m_cyc = 0; m_last_fall = -100; m_last_clr = -100;
         m_clr = 0; m_step = 0;
         m_state = 0; m_carry = 0; m_cnt = 0;
      end else begin
         bit all_diff_s, all_diff_c;
         m_cyc++;
         if (m_clr != 0) begin
            m_state = 0; m_carry = 0; m_cnt = 0;
         end else if (m_step != 0) begin
            m_carry = (m_state == 7) ? 1 : 0;
            m_cnt   = (m_cnt + m_carry) % 256;
            m_state = (m_state + 1) % 8;
         end
         for (int i = HN - 1; i > 0; i--) begin
            m_hs[i] = m_hs[i-1];
            m_hc[i] = m_hc[i-1];
         end
         m_hs[0] = int'(btn_step);
         m_hc[0] = int'(btn_clr);
         all_diff_s = 1'b1;
         all_diff_c = 1'b1;
         for (int i = 2; i < HN; i++) begin
            if (m_hs[i] == m_st_step) all_diff_s = 1'b0;
            if (m_hc[i] == m_st_clr)  all_diff_c = 1'b0;
         end
         m_clr = 0;
         if (all_diff_s) begin
            m_st_step = 1 - m_st_step;
            if (m_st_step == 0) m_last_fall = m_cyc;
         end
         if (all_diff_c) begin
            m_st_clr = 1 - m_st_clr;
            if (m_st_clr == 1) begin
               m_clr = 1;
               m_last_clr = m_cyc;
            end
         end
         m_step = ((m_last_fall == m_cyc - 2) && (m_last_clr < m_cyc - 3)) ? 1 : 0;
      end
   end

   always @(negedge clk) begin
      if (step_o) pulses++;
      if (cmp_en) begin
         chk("cyc_step_o",    int'(step_o),    m_step);
         chk("cyc_state_o",   int'(state_o),   m_state);
         chk("cyc_carry_o",   int'(carry_o),   m_carry);
         chk("cyc_carry_cnt", int'(carry_cnt), m_cnt);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
      #2;
   endtask

   task automatic press_release();
      btn_step = 1'b1;
      tick(7);
      btn_step = 1'b0;
      tick(10);
   endtask

   task automatic clear_press();
      btn_clr = 1'b1;
      tick(7);
      btn_clr = 1'b0;
      tick(10);
   endtask

   int p0;

   initial begin
      rst_n = 1'b0; btn_step = 1'b0; btn_clr = 1'b0; sw_auto = 1'b0;
      tick(3);
      chk("reset_state",  int'(state_o),   0);
      chk("reset_step",   int'(step_o),    0);
      chk("reset_carry",  int'(carry_o),   0);
      chk("reset_cnt",    int'(carry_cnt), 0);
      rst_n = 1'b1;
      tick(2);

      // three clean presses
      p0 = pulses;
      for (int i = 0; i < 3; i++) press_release();
      chk("three_pulses", pulses - p0, 3);
      chk("three_state",  int'(state_o), 3);
      chk("three_model",  m_state, 3);
      chk("three_carry",  int'(carry_o), 0);
      chk("three_cnt",    int'(carry_cnt), 0);

      // two-clock glitch
      p0 = pulses;
      btn_step = 1'b1;
      tick(2);
      btn_step = 1'b0;
      tick(12);
      chk("glitch_pulses", pulses - p0, 0);
      chk("glitch_state",  int'(state_o), 3);

      // clear, then a full lap and one more
      clear_press();
      chk("clear_state", int'(state_o), 0);
      for (int i = 0; i < 8; i++) press_release();
      chk("lap_state", int'(state_o), 0);
      chk("lap_carry", int'(carry_o), 1);
      chk("lap_cnt",   int'(carry_cnt), 1);
      press_release();
      chk("lap9_state", int'(state_o), 1);
      chk("lap9_carry", int'(carry_o), 0);
      chk("lap9_cnt",   int'(carry_cnt), 1);

      // 256 laps wrap the carry count
      clear_press();
      for (int i = 0; i < 1024; i++) press_release();
      chk("half_cnt", int'(carry_cnt), 128);
      for (int i = 0; i < 1024; i++) press_release();
      chk("wrap_cnt",   int'(carry_cnt), 0);
      chk("wrap_state", int'(state_o), 0);
      chk("wrap_carry", int'(carry_o), 1);

      // clear coinciding with a step strobe
      for (int i = 0; i < 8; i++) press_release();
      chk("pre_clr_cnt", int'(carry_cnt), 1);
      p0 = pulses;
      btn_step = 1'b1;
      tick(7);
      btn_step = 1'b0;
      tick(2);
      btn_clr = 1'b1;
      tick(7);
      btn_clr = 1'b0;
      tick(10);
      chk("coinc_pulses", pulses - p0, 0);
      chk("coinc_state",  int'(state_o), 0);
      chk("coinc_carry",  int'(carry_o), 0);
      chk("coinc_cnt",    int'(carry_cnt), 0);
      press_release();
      chk("after_clr_state", int'(state_o), 1);

      // reset in the middle of a debounce aborts the press
      p0 = pulses;
      btn_step = 1'b1;
      tick(4);
      rst_n = 1'b0;
      tick(1);
      chk("midrst_state", int'(state_o), 0);
      chk("midrst_step",  int'(step_o), 0);
      btn_step = 1'b0;
      tick(1);
      rst_n = 1'b1;
      tick(14);
      chk("midrst_pulses", pulses - p0, 0);

`ifdef STEP_AUTO_EN
      cmp_en = 1'b0;
      p0 = pulses;
      sw_auto = 1'b1;
      for (int i = 0; i < 2; i++) begin
         btn_step = 1'b1;
         tick(7);
         btn_step = 1'b0;
         tick(13);
      end
      chk("auto_pulses_ge4", (pulses - p0 >= 4) ? 1 : 0, 1);
      chk("auto_pulses_le5", (pulses - p0 <= 5) ? 1 : 0, 1);
      chk("auto_state", int'(state_o), (pulses - p0) % 8);
      rst_n = 1'b0;
      tick(1);
      chk("auto_rst_state", int'(state_o), 0);
      chk("auto_rst_step",  int'(step_o), 0);
      chk("auto_rst_cnt",   int'(carry_cnt), 0);
      sw_auto = 1'b0;
      rst_n = 1'b1;
      tick(3);
      cmp_en = 1'b1;
`else
      // without the auto feature the switch has no effect
      p0 = pulses;
      sw_auto = 1'b1;
      tick(20);
      chk("noauto_idle", pulses - p0, 0);
      press_release();
      chk("noauto_manual", pulses - p0, 1);
      chk("noauto_state",  int'(state_o), 1);
      sw_auto = 1'b0;
      tick(3);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seq_step_ctrl.md
Name: seq_step_ctrl

Overview:
- Clocked controller that sequences the board's 3-bit mod-8 state counter (states 0..7, carry z asserted on the 7→0 step).
- Replaces driving the counter directly from a raw button edge.
- Synchronizes and debounces the S1 step button and a clear button, then issues single-cycle step pulses.
- Holds the counter state and carry as registered outputs, and counts carries for LED display.
- Sits between the EGO1 button/switch pins and the led_pin bus in the top level.

Parameters:
- DB_CYCLES, 2000000, debounce stability window in clocks (20 ms at 100 MHz).
- AUTO_DIV, 50000000, auto-run step period in clocks (0.5 s at 100 MHz).

Ports:
- sys_clk_in  input  1  system clock, 100 MHz
- sys_rst_n  input  1  asynchronous active-low reset
- btn_step  input  1  raw S1 step button, active-high, asynchronous
- btn_clr  input  1  raw clear button, active-high, asynchronous
- sw_auto  input  1  raw auto-run switch, active-high (used only with STEP_AUTO_EN)
- step_o  output  1  one-cycle step strobe
- state_o  output  3  current counter state {y3,y2,y1}
- carry_o  output  1  z output of the most recent step
- carry_cnt  output  8  number of carries since reset/clear, mod 256

Behaviour:
- Reset (sys_rst_n=0, asynchronous):
  - step_o=0, state_o=0, carry_o=0, carry_cnt=0.
  - Synchronizers, debounce counters and prescaler all 0; FSM in S_IDLE.
- Input conditioning:
  - Each raw input passes a 2-FF synchronizer.
  - Each button has its own debouncer with a stable value and a counter. The counter clears whenever the synced input equals the stable value. Otherwise it increments; at DB_CYCLES-1 the stable value takes the synced input and the counter clears.
  - Glitches shorter than DB_CYCLES clocks never change the stable value.
- Step FSM, manual path:
  - S_IDLE: stable btn_step=1 → S_PRESSED.
  - S_PRESSED: stable btn_step=0 (release, i.e. falling edge) → S_STEP.
  - S_STEP: step_o=1 for exactly this cycle → S_IDLE.
  - One press/release yields exactly one step; holding the button yields none until release.
- On each cycle with step_o=1 (registered, visible the following cycle):
  - state_o <= (state_o+1) mod 8.
  - carry_o <= 1 if the old state_o==7, else 0.
  - carry_cnt <= carry_cnt+1 (wraps 255→0) if the old state_o==7.
  - carry_o holds its value between steps.
- Clear:
  - Rising edge of stable btn_clr produces a one-cycle clear, which zeroes state_o, carry_o and carry_cnt and forces the FSM to S_IDLE.
  - Clear has priority: a step_o in the same cycle is suppressed (step_o forced 0, no update).
- Latency: release settles in the debouncer after DB_CYCLES+2 clocks; step_o fires 2 cycles later; state_o updates 1 cycle after step_o.
- A reset asserted mid-debounce or mid-step aborts everything; no step is issued after reset release until a fresh press/release.

Optional Feature:
- Macro: STEP_AUTO_EN.
- Defined:
  - Synced sw_auto=1 runs a prescaler that counts 0..AUTO_DIV-1 and asserts step_o for one cycle when it reaches AUTO_DIV-1, then restarts at 0.
  - Manual steps are ignored while auto is active; the FSM is held in S_IDLE.
  - sw_auto=0 holds the prescaler at 0.
  - Clear still has priority and also zeroes the prescaler.
- Not defined:
  - sw_auto is ignored and no prescaler logic is built.
  - The port remains, so the top level is identical.

Test Plan (sim with DB_CYCLES=4, AUTO_DIV=8):
- Reset then 3 clean press/release cycles → exactly 3 step_o pulses; state_o 0→1→2→3; carry_o=0; carry_cnt=0.
- btn_step glitch high for 2 clocks → no step_o; state_o unchanged.
- 8 press/release cycles from 0 → state_o back to 0; carry_o=1 after the 8th step and 0 after the 9th; carry_cnt=1.
- 256×8 steps → carry_cnt wraps to 0 while state_o=0.
- Clear press arriving in the same cycle as a step → step_o=0; state_o=0, carry_o=0, carry_cnt=0; the next press/release gives state_o=1.
- STEP_AUTO_EN with sw_auto=1 for 40 clocks → step_o every 8 clocks (≈5 pulses) and manual presses ignored; sys_rst_n pulsed low mid-run → all outputs 0 immediately.
